// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
//  Module : cdb_arbiter_pkg
//  Brief  : Shared sizes, tag constants and requester names for the CDB arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cdb_arbiter_pkg;

    localparam int CDB_N_REQ   = 4;
    localparam int CDB_DATA_W  = 32;
    localparam int CDB_LABEL_W = 4;

    // Tag value meaning "no producer"; such a request is never granted.
    localparam logic [CDB_LABEL_W-1:0] LABEL_NONE = '0;

    typedef enum int {
        CDB_ALU = 0,
        CDB_MUL = 1,
        CDB_DIV = 2,
        CDB_LS  = 3
    } cdb_unit_e;

endpackage : cdb_arbiter_pkg

`default_nettype wire

// File: rtl/cdb_arbiter_rr_picker.sv
// ============================================================================
//  Module : rr_picker
//  Brief  : Combinational rotating priority encoder (search starts at i_ptr).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_grant_idx,
    output logic             o_grant_valid
);

    always_comb begin : p_pick
        int idx;
        idx           = 0;
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(i_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!o_grant_valid && i_eligible[idx]) begin
                o_grant[idx]  = 1'b1;
                o_grant_idx   = PTR_W'(idx);
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule : rr_picker

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
//  Module : cdb_arbiter
//  Brief  : Registered round-robin Common Data Bus arbiter; optional stall
//           counter enabled by defining CDB_STATS_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ   = CDB_N_REQ,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int LABEL_W = CDB_LABEL_W
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         require,
    input  logic [N_REQ*DATA_W-1:0]  dataIn,
    input  logic [N_REQ*LABEL_W-1:0] labelIn,
    output logic [N_REQ-1:0]         requireAC,
    output logic                     BCEN,
    output logic [DATA_W-1:0]        BCdata,
    output logic [LABEL_W-1:0]       BClabel
`ifdef CDB_STATS_EN
    ,
    output logic [15:0]              stallCnt
`endif
);

    localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(N_REQ - 1);

    logic [c_PTR_W-1:0] r_ptr;
    logic               r_bc_en;
    logic [DATA_W-1:0]  r_bc_data;
    logic [LABEL_W-1:0] r_bc_label;

    logic [N_REQ-1:0]   w_eligible;
    logic [N_REQ-1:0]   w_grant;
    logic [c_PTR_W-1:0] w_grant_idx;
    logic               w_grant_valid;
    logic [c_PTR_W-1:0] w_ptr_next;
    logic [DATA_W-1:0]  w_data  [N_REQ];
    logic [LABEL_W-1:0] w_label [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign w_data[i]     = dataIn[i*DATA_W +: DATA_W];
        assign w_label[i]    = labelIn[i*LABEL_W +: LABEL_W];
        assign w_eligible[i] = require[i] && (w_label[i] != LABEL_W'(LABEL_NONE));
    end

    rr_picker #(
        .N     (N_REQ),
        .PTR_W (c_PTR_W)
    ) u_picker (
        .i_eligible    (w_eligible),
        .i_ptr         (r_ptr),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // Grant is suppressed while reset is held so no unit retires a result that is never broadcast.
    assign requireAC  = RST ? '0 : w_grant;
    assign w_ptr_next = (w_grant_idx == c_LAST_IDX) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_ptr      <= '0;
            r_bc_en    <= 1'b0;
            r_bc_data  <= '0;
            r_bc_label <= '0;
        end else if (w_grant_valid) begin
            r_ptr      <= w_ptr_next;
            r_bc_en    <= 1'b1;
            r_bc_data  <= w_data[w_grant_idx];
            r_bc_label <= w_label[w_grant_idx];
        end else begin
            r_bc_en    <= 1'b0;
        end
    end

    assign BCEN    = r_bc_en;
    assign BCdata  = r_bc_data;
    assign BClabel = r_bc_label;

`ifdef CDB_STATS_EN
    logic        w_any_stall;
    logic [15:0] r_stall_cnt;

    assign w_any_stall = |(w_eligible & ~w_grant);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_any_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stallCnt = r_stall_cnt;
`else
    // Statistics disabled: no stall counter is built.
`endif

endmodule : cdb_arbiter

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
//  Module : tb_cdb_arbiter
//  Brief  : Directed self-checking bench for cdb_arbiter (CDB_STATS_EN aware).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

    logic         clk;
    logic         RST;
    logic [3:0]   require;
    logic [127:0] dataIn;
    logic [15:0]  labelIn;
    logic [3:0]   requireAC;
    logic         BCEN;
    logic [31:0]  BCdata;
    logic [3:0]   BClabel;
`ifdef CDB_STATS_EN
    logic [15:0]  stallCnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    cdb_arbiter dut (
        .clk       (clk),
        .RST       (RST),
        .require   (require),
        .dataIn    (dataIn),
        .labelIn   (labelIn),
        .requireAC (requireAC),
        .BCEN      (BCEN),
        .BCdata    (BCdata),
        .BClabel   (BClabel)
`ifdef CDB_STATS_EN
        ,
        .stallCnt  (stallCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bc(input string tag, input logic en, input logic [3:0] lab, input logic [31:0] dat);
        check({tag, "_bcen"},  {31'd0, BCEN}, {31'd0, en});
        check({tag, "_label"}, {28'd0, BClabel}, {28'd0, lab});
        check({tag, "_data"},  BCdata, dat);
    endtask

    localparam logic [15:0]  c_LAB_ALL = 16'h4321;
    localparam logic [127:0] c_DAT_ALL = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};

    initial begin
        RST     = 1'b1;
        require = 4'b0000;
        dataIn  = '0;
        labelIn = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ac", {28'd0, requireAC}, 32'd0);
        check_bc("rst", 1'b0, 4'd0, 32'd0);
        RST = 1'b0;

        // ALU alone with tag 3, three cycles in a row
        require = 4'b0001;
        labelIn = 16'h0003;
        dataIn  = {96'd0, 32'h0000_00AA};
        for (int c = 0; c < 3; c++) begin
            #1;
            check("alu_ac", {28'd0, requireAC}, 32'h1);
            tick();
            check_bc("alu", 1'b1, 4'd3, 32'h0000_00AA);
        end
        require = 4'b0000;
        #1;
        check("idle_ac", {28'd0, requireAC}, 32'd0);
        tick();
        check_bc("idle_hold", 1'b0, 4'd3, 32'h0000_00AA);

        // Reset asserted mid-stream with everyone requesting
        RST     = 1'b1;
        require = 4'b1111;
        labelIn = c_LAB_ALL;
        dataIn  = c_DAT_ALL;
        #1;
        check("midrst_ac", {28'd0, requireAC}, 32'd0);
        check_bc("midrst", 1'b0, 4'd0, 32'd0);
        tick();
        check("midrst_edge_bcen", {31'd0, BCEN}, 32'd0);
        RST = 1'b0;

        // Full rotation 0,1,2,3,0
        for (int g = 0; g < 5; g++) begin
            #1;
            check("rot_ac", {28'd0, requireAC}, 32'(1 << (g % 4)));
            tick();
            check_bc("rot", 1'b1, 4'((g % 4) + 1), 32'h100 + 32'(g % 4));
        end

        // ptr is 1: grant unit 1 to move ptr to 2
        require = 4'b0010;
        #1;
        check("p2_ac", {28'd0, requireAC}, 32'h2);
        tick();
        check_bc("p2", 1'b1, 4'd2, 32'h0000_0101);

        // ptr=2 with 1010: unit 3 first, wrap to 0, then unit 1
        require = 4'b1010;
        #1;
        check("wrap_ac3", {28'd0, requireAC}, 32'h8);
        tick();
        check_bc("wrap3", 1'b1, 4'd4, 32'h0000_0103);
        require = 4'b0010;
        #1;
        check("wrap_ac1", {28'd0, requireAC}, 32'h2);
        tick();
        check_bc("wrap1", 1'b1, 4'd2, 32'h0000_0101);

        // ptr should now be 2
        require = 4'b1111;
        #1;
        check("ptr2_ac", {28'd0, requireAC}, 32'h4);
        tick();
        check_bc("ptr2", 1'b1, 4'd3, 32'h0000_0102);

        // Tag 0 request on unit 2 is ignored
        require = 4'b0100;
        labelIn = 16'h4021;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("tag0_ac", {28'd0, requireAC}, 32'd0);
            tick();
            check_bc("tag0", 1'b0, 4'd3, 32'h0000_0102);
        end

        // ptr is 3: grant unit 3, then async reset between edges
        require = 4'b1111;
        labelIn = c_LAB_ALL;
        #1;
        check("p3_ac", {28'd0, requireAC}, 32'h8);
        tick();
        check_bc("p3", 1'b1, 4'd4, 32'h0000_0103);
        #2;
        RST = 1'b1;
        #1;
        check("async_ac", {28'd0, requireAC}, 32'd0);
        check_bc("async", 1'b0, 4'd0, 32'd0);
        tick();
        RST = 1'b0;
        #1;
        check("post_rst_ac", {28'd0, requireAC}, 32'h1);
        tick();
        check_bc("post_rst", 1'b1, 4'd1, 32'h0000_0100);

`ifdef CDB_STATS_EN
        RST = 1'b1;
        tick();
        check("stall_rst", {16'd0, stallCnt}, 32'd0);
        RST = 1'b0;
        repeat (10) tick();
        check("stall_10", {16'd0, stallCnt}, 32'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_cdb_arbiter

`default_nettype wire
